fcmp_arbiter: RTL and testbench

FCMP_ARBITER -- requirements
Module: fcmp_arbiter

---
 rtl/fcmp_arbiter_pkg.sv | 15 +
 rtl/fcmp_arbiter_if.sv | 26 ++
 rtl/fcmp_arbiter_tag_fifo.sv | 54 +++++
 rtl/fcmp_arbiter.sv | 140 ++++++++++++++
 tb/tb_fcmp_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fcmp_arbiter_pkg.sv
// Shared types and constants for the floating-point compare arbiter.
package fcmp_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    localparam int CNT_W = 16;

    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fcmp_arbiter_if.sv
// Operand and result channels between the arbiter and the shared compare unit.
interface fcmp_arbiter_if #(
    parameter int SIZE = 32
);
    logic [SIZE-1:0] m_axis_a_tdata;
    logic            m_axis_a_tvalid;
    logic            m_axis_a_tready;
    logic [SIZE-1:0] m_axis_b_tdata;
    logic            m_axis_b_tvalid;
    logic            m_axis_b_tready;
    logic [7:0]      s_axis_result_tdata;
    logic            s_axis_result_tvalid;
    logic            s_axis_result_tready;

    modport master (
        output m_axis_a_tdata, m_axis_a_tvalid, input m_axis_a_tready,
        output m_axis_b_tdata, m_axis_b_tvalid, input m_axis_b_tready,
        input  s_axis_result_tdata, s_axis_result_tvalid, output s_axis_result_tready
    );

    modport slave (
        input  m_axis_a_tdata, m_axis_a_tvalid, output m_axis_a_tready,
        input  m_axis_b_tdata, m_axis_b_tvalid, output m_axis_b_tready,
        output s_axis_result_tdata, s_axis_result_tvalid, input s_axis_result_tready
    );
endinterface

// File: rtl/fcmp_arbiter_tag_fifo.sv
// In-order FIFO of requester indices for compares in flight; push and pop may
// coincide when full.
module fcmp_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign head  = mem_q[rd_q];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (do_push) wr_d = wr_q + PW'(1);
        if (do_pop)  rd_d = rd_q + PW'(1);
        if (do_push && !do_pop)      cnt_d = cnt_q + (PW+1)'(1);
        else if (do_pop && !do_push) cnt_d = cnt_q - (PW+1)'(1);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end
endmodule

// File: rtl/fcmp_arbiter.sv
// Round-robin arbiter sharing one compare unit among NUM_REQ requesters, with
// in-order result routing. Optional per-requester issue counters: FCMP_ARB_STATS_EN.
module fcmp_arbiter
    import fcmp_arb_pkg::*;
#(
    parameter int SIZE    = 32,
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*SIZE-1:0] req_a,
    input  logic [NUM_REQ*SIZE-1:0] req_b,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [NUM_REQ-1:0]      resp_lt,
    fcmp_arbiter_if.master          cu
`ifdef FCMP_ARB_STATS_EN
    , output logic [NUM_REQ*CNT_W-1:0] grant_count
`endif
);
    localparam int TW = tag_width(NUM_REQ);

    arb_state_e      state_q, state_d;
    logic [TW-1:0]   grant_q, grant_d, last_q, last_d;
    logic [SIZE-1:0] a_q, a_d, b_q, b_d;
    logic [TW-1:0]   rr_pick, sel, tag_head;
    logic            rr_found, offer, accept;
    logic [SIZE-1:0] off_a, off_b;
    logic            tag_empty, tag_full, res_hs;
    logic [6:0]      unused_tdata;

    assign unused_tdata = cu.s_axis_result_tdata[7:1];

    // First valid requester strictly after the last granted one, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!rr_found && req_valid[(int'(last_q) + i) % NUM_REQ]) begin
                rr_found = 1'b1;
                rr_pick  = TW'((int'(last_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        a_d     = a_q;
        b_d     = b_q;
        last_d  = last_q;
        offer   = 1'b0;
        sel     = grant_q;
        off_a   = a_q;
        off_b   = b_q;
        case (state_q)
            ARB: begin
                offer = rr_found && !tag_full;
                sel   = rr_pick;
                off_a = req_a[rr_pick*SIZE +: SIZE];
                off_b = req_b[rr_pick*SIZE +: SIZE];
            end
            HOLD: offer = 1'b1;
            default: ;
        endcase
        accept = aresetn && offer && cu.m_axis_a_tready && cu.m_axis_b_tready;
        if (accept) begin
            last_d  = sel;
            state_d = ARB;
        end else if (offer) begin
            state_d = HOLD;
            grant_d = sel;
            a_d     = off_a;
            b_d     = off_b;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ARB;
            grant_q <= '0;
            last_q  <= TW'(NUM_REQ - 1);
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // tvalid depends only on state, requests and FIFO occupancy, never on tready.
    assign cu.m_axis_a_tvalid = offer && aresetn;
    assign cu.m_axis_b_tvalid = offer && aresetn;
    assign cu.m_axis_a_tdata  = off_a;
    assign cu.m_axis_b_tdata  = off_b;
    assign req_ready          = accept ? (NUM_REQ'(1) << sel) : '0;

    fcmp_tag_fifo #(
        .DEPTH (MAX_OUT),
        .W     (TW)
    ) u_tag_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (accept),
        .push_data (sel),
        .pop       (res_hs),
        .head      (tag_head),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    // Results with no outstanding tag are accepted and dropped.
    assign cu.s_axis_result_tready = tag_empty ? 1'b1 : resp_ready[tag_head];
    assign res_hs     = cu.s_axis_result_tvalid && cu.s_axis_result_tready;
    assign resp_valid = (!tag_empty && aresetn && cu.s_axis_result_tvalid)
                        ? (NUM_REQ'(1) << tag_head) : '0;
    assign resp_lt    = !tag_empty ? (NUM_REQ'(cu.s_axis_result_tdata[0]) << tag_head) : '0;

`ifdef FCMP_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        logic [CNT_W-1:0] cnt_q, cnt_d;
        always_comb begin
            cnt_d = cnt_q;
            if (accept && sel == TW'(gi) && cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + CNT_W'(1);
        end
        always_ff @(posedge aclk) begin
            if (!aresetn) cnt_q <= '0;
            else          cnt_q <= cnt_d;
        end
        assign grant_count[gi*CNT_W +: CNT_W] = cnt_q;
    end
`endif
endmodule

// File: tb/tb_fcmp_arbiter.sv
// Randomized and directed bench for fcmp_arbiter against a queue-based model,
// with a behavioural 3-cycle compare unit on the shared channel.
module tb_fcmp_arbiter;
    localparam int N = 4, S = 32, MO = 4, LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            aresetn;
    logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready, resp_lt;
    logic [N*S-1:0]  req_a, req_b;
`ifdef FCMP_ARB_STATS_EN
    logic [N*16-1:0] grant_count;
`endif

    fcmp_arbiter_if #(.SIZE(S)) cu ();

    fcmp_arbiter #(.SIZE(S), .NUM_REQ(N), .MAX_OUT(MO)) dut (
        .aclk       (clk),
        .aresetn    (aresetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_lt    (resp_lt),
        .cu         (cu)
`ifdef FCMP_ARB_STATS_EN
        , .grant_count (grant_count)
`endif
    );

    int errors = 0, checks = 0;
    logic [63:0] jobs [N][$];
    bit          exp_lt_q [N][$];
    int          tags [$];
    bit          m_pend;
    int          m_pgrant, m_last;
    bit          u_lt [$];
    int          u_due [$];
    int          cyc = 0, acc_cyc = 0, rv_cyc = -1;
    int          grant_log [$];
    int          cnt_m [N];
    bit          ctl_ta, ctl_tb, last_lt0;
    logic [N-1:0] ctl_rr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit fp_lt(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'h0 && b[30:0] == 31'h0) return 1'b0;
        if (a[31] != b[31]) return a[31];
        if (!a[31]) return a[30:0] < b[30:0];
        return a[30:0] > b[30:0];
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return last;
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        v = $urandom;
        v[30:23] = 8'($urandom_range(0, 254));
        return v;
    endfunction

    function automatic bit busy();
        for (int i = 0; i < N; i++) if (jobs[i].size() > 0) return 1'b1;
        return (tags.size() > 0) || m_pend || (u_lt.size() > 0);
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic step();
        bit offer, acc, mpop, u_v, op_hs, op_lt, res_hs, exp_str;
        int g, h, c;
        logic [N-1:0] exp_rr, exp_rv, rq_acc;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (jobs[i].size() > 0);
            req_a[i*S +: S] = 32'h0;
            req_b[i*S +: S] = 32'h0;
            if (jobs[i].size() > 0) begin
                req_a[i*S +: S] = jobs[i][0][63:32];
                req_b[i*S +: S] = jobs[i][0][31:0];
            end
        end
        u_v = (u_lt.size() > 0) && (u_due[0] <= cyc);
        cu.s_axis_result_tvalid = u_v;
        cu.s_axis_result_tdata  = {7'($urandom), 1'b0};
        if (u_v) cu.s_axis_result_tdata[0] = u_lt[0];
        cu.m_axis_a_tready = ctl_ta;
        cu.m_axis_b_tready = ctl_tb;
        resp_ready = ctl_rr;
        #3;
        offer  = aresetn && (m_pend || (req_valid != '0 && tags.size() < MO));
        g      = m_pend ? m_pgrant : rr_pick(req_valid, m_last);
        acc    = offer && ctl_ta && ctl_tb;
        exp_rr = acc ? (N'(1) << g) : '0;
        exp_rv = '0;
        exp_str = 1'b1;
        h = 0;
        if (tags.size() > 0) begin
            h = tags[0];
            exp_str = ctl_rr[h];
            if (u_v) exp_rv[h] = 1'b1;
        end
        mpop = (tags.size() > 0) && u_v && exp_str;
        if (aresetn) begin
            chk("a_tvalid", cu.m_axis_a_tvalid, offer);
            chk("b_tvalid", cu.m_axis_b_tvalid, offer);
            if (offer) begin
                chk("a_tdata", cu.m_axis_a_tdata, jobs[g][0][63:32]);
                chk("b_tdata", cu.m_axis_b_tdata, jobs[g][0][31:0]);
            end
            chk("req_ready", req_ready, exp_rr);
            chk("res_tready", cu.s_axis_result_tready, exp_str);
            chk("resp_valid", resp_valid, exp_rv);
            if (exp_rv != '0) chk("resp_lt", resp_lt[h], exp_lt_q[h][0]);
        end
        rq_acc = req_ready;
        op_hs  = cu.m_axis_a_tvalid && cu.m_axis_a_tready && cu.m_axis_b_tvalid && cu.m_axis_b_tready;
        op_lt  = fp_lt(cu.m_axis_a_tdata, cu.m_axis_b_tdata);
        res_hs = u_v && cu.s_axis_result_tready;
        for (int i = 0; i < N; i++)
            if (rq_acc[i] === 1'b1) begin
                grant_log.push_back(i);
                acc_cyc = cyc;
                $display("cycle %0d: issue req%0d a=%h b=%h", cyc, i, req_a[i*S +: S], req_b[i*S +: S]);
            end
        if (resp_valid[0] === 1'b1) last_lt0 = resp_lt[0];
        if (resp_valid != '0 && resp_valid !== 'x && rv_cyc < 0) rv_cyc = cyc;
        c = cyc;
        @(posedge clk);
        cyc++;
        if (!aresetn) begin
            m_pend = 1'b0;
            m_last = N - 1;
            tags.delete();
            u_lt.delete();
            u_due.delete();
            for (int i = 0; i < N; i++) begin
                exp_lt_q[i].delete();
                cnt_m[i] = 0;
            end
        end else begin
            if (mpop) begin
                void'(exp_lt_q[h].pop_front());
                void'(tags.pop_front());
            end
            if (acc) begin
                tags.push_back(g);
                exp_lt_q[g].push_back(fp_lt(jobs[g][0][63:32], jobs[g][0][31:0]));
                m_last = g;
                m_pend = 1'b0;
                if (cnt_m[g] < 65535) cnt_m[g]++;
            end else if (offer) begin
                m_pend   = 1'b1;
                m_pgrant = g;
            end
            if (res_hs) begin
                void'(u_lt.pop_front());
                void'(u_due.pop_front());
            end
            if (op_hs) begin
                u_lt.push_back(op_lt);
                u_due.push_back(c + LAT);
            end
        end
        for (int i = 0; i < N; i++)
            if (rq_acc[i] === 1'b1 && jobs[i].size() > 0) void'(jobs[i].pop_front());
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (busy() && n < 600) begin
            step();
            n++;
        end
        chk("drain_bound", n < 600, 1'b1);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        step();
        step();
        aresetn = 1'b1;
    endtask

    initial begin
        int n;
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        aresetn = 1'b0;
        ctl_ta = 1'b1;
        ctl_tb = 1'b1;
        ctl_rr = '1;
        #1;
        do_reset();

        // Reset state with nothing requested.
        step();
        step();

        // 1.0 < 2.0 from requester 0; result three cycles after issue.
        rv_cyc = -1;
        jobs[0].push_back({32'h3F80_0000, 32'h4000_0000});
        drain();
        chk("lat_resp", rv_cyc - acc_cyc, LAT);
        chk("lt_1_vs_2", last_lt0, 1'b1);

        // All four requesters valid from reset: strict rotation.
        do_reset();
        grant_log.delete();
        for (int i = 0; i < N; i++)
            repeat (2) jobs[i].push_back({rnd_fp(), rnd_fp()});
        drain();
        for (int i = 0; i < 5; i++) chk("rr_order", grant_log[i], exp_seq[i]);

        // Requester 2 back-pressures its results: four issue, then the FIFO stalls.
        grant_log.delete();
        ctl_rr = 4'b1011;
        repeat (6) jobs[2].push_back({rnd_fp(), rnd_fp()});
        repeat (12) step();
        chk("full_issues", grant_log.size(), MO);
        chk("full_tready", cu.s_axis_result_tready, 1'b0);
        ctl_rr = '1;
        drain();
        chk("full_no_loss", grant_log.size(), 6);

        // Held offer for req1 is not displaced by req3 (next in rotation after 2).
        grant_log.delete();
        ctl_ta = 1'b0;
        jobs[1].push_back({rnd_fp(), rnd_fp()});
        repeat (2) step();
        jobs[3].push_back({rnd_fp(), rnd_fp()});
        repeat (3) step();
        ctl_ta = 1'b1;
        drain();
        chk("hold_first", grant_log[0], 1);
        chk("hold_second", grant_log[1], 3);

        // Reset with three compares in flight.
        grant_log.delete();
        ctl_rr = '0;
        for (int i = 0; i < 3; i++) jobs[i].push_back({rnd_fp(), rnd_fp()});
        n = 0;
        while (grant_log.size() < 3 && n < 50) begin
            step();
            n++;
        end
        chk("inflight_issued", grant_log.size(), 3);
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        ctl_rr = '1;
        step();
        chk("post_rst_valids", {resp_valid, req_ready, cu.m_axis_a_tvalid, cu.m_axis_b_tvalid}, '0);
        grant_log.delete();
        for (int i = 1; i <= N; i++) jobs[i % N].push_back({rnd_fp(), rnd_fp()});
        drain();
        chk("post_rst_first", grant_log[0], 0);

`ifdef FCMP_ARB_STATS_EN
        do_reset();
        repeat (10) jobs[1].push_back({rnd_fp(), rnd_fp()});
        drain();
        chk("gcnt1_ten", grant_count[31:16], 10);
        for (int i = 0; i < N; i++) chk("gcnt", grant_count[i*16 +: 16], cnt_m[i]);
`endif

        // Random traffic with random back-pressure and occasional resets.
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0 && jobs[i].size() < 4) begin
                    logic [31:0] a;
                    a = rnd_fp();
                    jobs[i].push_back({a, ($urandom_range(0, 7) == 0) ? a : rnd_fp()});
                end
            ctl_ta = ($urandom_range(0, 3) != 0);
            ctl_tb = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) ctl_rr[i] = ($urandom_range(0, 3) != 0);
            aresetn = ($urandom_range(0, 299) != 0);
            step();
        end
        aresetn = 1'b1;
        ctl_ta = 1'b1;
        ctl_tb = 1'b1;
        ctl_rr = '1;
        drain();
`ifdef FCMP_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("gcnt_rand", grant_count[i*16 +: 16], cnt_m[i]);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
